// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO write/read controllers.
package fifo_pkg;

  localparam int PTR_WIDTH_DEF = 3;
  localparam int DEPTH_DEF     = 1 << PTR_WIDTH_DEF;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Full when the two top Gray bits differ and the rest match (pw+1 bit pointers).
  function automatic logic ptr_full(input logic [31:0] wg, input logic [31:0] rg,
                                    input int unsigned pw);
    logic [31:0] inv;
    logic [31:0] mask;
    inv  = 32'd3 << (pw - 1);
    mask = (32'd1 << (pw + 1)) - 32'd1;
    return ((wg ^ rg ^ inv) & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter.sv
// Combinational round-robin pick: first set req at or above rr_ptr, wrapping.
module fifo_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      gnt_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (en && !found && req[idx]) begin
        found        = 1'b1;
        grant[idx]   = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side FIFO controller: round-robin requester arbitration, write pointers, full.
// Optional FIFO_WR_ARB_BURST_EN keeps a grant for up to BURST_LEN beats.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int PTR_WIDTH = PTR_WIDTH_DEF,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                     w_clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       grant,
  input  logic [PTR_WIDTH:0]       r_ptr_gray_sync,
  output logic                     write_en,
  output logic [WIDTH-1:0]         w_data,
  output logic [PTR_WIDTH:0]       w_ptr,
  output logic [PTR_WIDTH:0]       w_ptr_gray,
  output logic                     full
);

  localparam int PW1 = PTR_WIDTH + 1;
  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (DEPTH != (1 << PTR_WIDTH) || PTR_WIDTH < 2 || NUM_REQ < 2 || BURST_LEN < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: illegal parameter combination");
  end

  logic [PTR_WIDTH:0] r_w_ptr, r_w_gray, w_next_bin, w_next_gray;
  logic [IW-1:0]      r_rr_ptr, w_gnt_idx, w_gnt_inc;
  logic               w_full, w_arb_en;

  assign w_full   = ptr_full(32'(r_w_gray), 32'(r_ptr_gray_sync), PTR_WIDTH);
  // Gating with reset keeps grant/write_en low for the whole reset window.
  assign w_arb_en = reset & ~w_full;

  fifo_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req     (req),
    .rr_ptr  (r_rr_ptr),
    .en      (w_arb_en),
    .grant   (grant),
    .gnt_idx (w_gnt_idx)
  );

  assign write_en    = |grant;
  assign w_data      = write_en ? req_data[w_gnt_idx*WIDTH +: WIDTH] : '0;
  assign w_gnt_inc   = (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_next_bin  = r_w_ptr + 1'b1;
  assign w_next_gray = PW1'(bin2gray(32'(w_next_bin)));

  assign w_ptr      = r_w_ptr;
  assign w_ptr_gray = r_w_gray;
  assign full       = w_full;

  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      r_w_ptr  <= '0;
      r_w_gray <= '0;
    end else if (write_en) begin
      r_w_ptr  <= w_next_bin;
      r_w_gray <= w_next_gray;
    end
  end

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int BCW = $clog2(BURST_LEN + 1);

  logic [BCW-1:0] r_burst_cnt, w_beats;
  logic [IW-1:0]  w_rr_inc;

  // rr_ptr parks on the burst owner, so a grant elsewhere means a fresh burst.
  assign w_beats  = (w_gnt_idx == r_rr_ptr) ? r_burst_cnt + 1'b1 : BCW'(1);
  assign w_rr_inc = (r_rr_ptr == IW'(NUM_REQ - 1)) ? '0 : r_rr_ptr + 1'b1;

  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else if (write_en) begin
      if (w_beats == BCW'(BURST_LEN)) begin
        r_rr_ptr    <= w_gnt_inc;
        r_burst_cnt <= '0;
      end else begin
        r_rr_ptr    <= w_gnt_idx;
        r_burst_cnt <= w_beats;
      end
    end else if (r_burst_cnt != '0 && !req[r_rr_ptr]) begin
      // Owner dropped req with nobody else to take over: close the burst.
      r_rr_ptr    <= w_rr_inc;
      r_burst_cnt <= '0;
    end
  end
`else
  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset)        r_rr_ptr <= '0;
    else if (write_en) r_rr_ptr <= w_gnt_inc;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed vector bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=8, PTR_WIDTH=3).
module tb_fifo_wr_arbiter;

  logic        w_clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  r_ptr_gray_sync;
  logic        write_en;
  logic [7:0]  w_data;
  logic [3:0]  w_ptr;
  logic [3:0]  w_ptr_gray;
  logic        full;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(
    .WIDTH(8), .DEPTH(8), .PTR_WIDTH(3), .NUM_REQ(4), .BURST_LEN(4)
  ) dut (
    .w_clk           (w_clk),
    .reset           (reset),
    .req             (req),
    .req_data        (req_data),
    .grant           (grant),
    .r_ptr_gray_sync (r_ptr_gray_sync),
    .write_en        (write_en),
    .w_data          (w_data),
    .w_ptr           (w_ptr),
    .w_ptr_gray      (w_ptr_gray),
    .full            (full)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] rg;
    logic [3:0] grant;
    logic       wen;
    logic [7:0] wdata;
    logic [3:0] wptr;
    logic [3:0] wgray;
    logic       full;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " grant"}, 32'(grant), 32'h0);
    chk({tag, " write_en"}, 32'(write_en), 32'h0);
    chk({tag, " w_data"}, 32'(w_data), 32'h0);
    chk({tag, " w_ptr"}, 32'(w_ptr), 32'h0);
    chk({tag, " w_ptr_gray"}, 32'(w_ptr_gray), 32'h0);
  endtask

  logic [3:0] seq[8];

  initial begin
    // req, rg, grant, wen, wdata, wptr, wgray, full  (w_ptr values are pre-edge)
    vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 4'h0, 4'b0000, 1'b0};
    vecs[1]  = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 8'hA0, 4'h0, 4'b0000, 1'b0};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 8'hA1, 4'h1, 4'b0001, 1'b0};
    vecs[3]  = '{4'b1111, 4'b0000, 4'b0100, 1'b1, 8'hA2, 4'h2, 4'b0011, 1'b0};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b1000, 1'b1, 8'hA3, 4'h3, 4'b0010, 1'b0};
    vecs[5]  = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 8'hA0, 4'h4, 4'b0110, 1'b0};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 8'hA1, 4'h5, 4'b0111, 1'b0};
    vecs[7]  = '{4'b1111, 4'b0000, 4'b0100, 1'b1, 8'hA2, 4'h6, 4'b0101, 1'b0};
    vecs[8]  = '{4'b1111, 4'b0000, 4'b1000, 1'b1, 8'hA3, 4'h7, 4'b0100, 1'b0};
    vecs[9]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 8'h00, 4'h8, 4'b1100, 1'b1};
    vecs[10] = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 8'h00, 4'h8, 4'b1100, 1'b1};
    vecs[11] = '{4'b1111, 4'b0001, 4'b0001, 1'b1, 8'hA0, 4'h8, 4'b1100, 1'b0};
    vecs[12] = '{4'b1111, 4'b0001, 4'b0000, 1'b0, 8'h00, 4'h9, 4'b1101, 1'b1};
    vecs[13] = '{4'b0100, 4'b0110, 4'b0100, 1'b1, 8'hA2, 4'h9, 4'b1101, 1'b0};
    vecs[14] = '{4'b0100, 4'b0110, 4'b0100, 1'b1, 8'hA2, 4'hA, 4'b1111, 1'b0};
    vecs[15] = '{4'b0100, 4'b0110, 4'b0100, 1'b1, 8'hA2, 4'hB, 4'b1110, 1'b0};
    vecs[16] = '{4'b1111, 4'b0110, 4'b0000, 1'b0, 8'h00, 4'hC, 4'b1010, 1'b1};
    vecs[17] = '{4'b1111, 4'b0111, 4'b1000, 1'b1, 8'hA3, 4'hC, 4'b1010, 1'b0};
    vecs[18] = '{4'b1111, 4'b0111, 4'b0000, 1'b0, 8'h00, 4'hD, 4'b1011, 1'b1};

    req             = 4'b1111;
    req_data        = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    r_ptr_gray_sync = 4'b0000;
    reset           = 1'b0;
    #2;
    check_zero("in_reset");
    repeat (2) tick();
    req   = 4'b0000;
    reset = 1'b1;
    #1;

    foreach (vecs[i]) begin
      req             = vecs[i].req;
      r_ptr_gray_sync = vecs[i].rg;
      #1;
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].grant));
      chk($sformatf("v%0d write_en", i), 32'(write_en), 32'(vecs[i].wen));
      chk($sformatf("v%0d w_data", i), 32'(w_data), 32'(vecs[i].wdata));
      chk($sformatf("v%0d w_ptr", i), 32'(w_ptr), 32'(vecs[i].wptr));
      chk($sformatf("v%0d w_ptr_gray", i), 32'(w_ptr_gray), 32'(vecs[i].wgray));
      chk($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].full));
      tick();
    end

    // Asynchronous reset mid-stream with w_ptr=5.
    reset = 1'b0;
    #1;
    reset           = 1'b1;
    r_ptr_gray_sync = 4'b0000;
    req             = 4'b1111;
    repeat (5) tick();
    chk("pre_rst w_ptr", 32'(w_ptr), 32'h5);
    chk("pre_rst grant", 32'(grant), 32'h2);
    #2;
    reset = 1'b0;
    #1;
    check_zero("async_rst");
    tick();
    check_zero("rst_held");
    reset = 1'b1;
    #1;
    chk("post_rst grant", 32'(grant), 32'h1);

    // Two active requesters: rotation per beat, or 4-beat bursts when enabled.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    req   = 4'b0011;
`ifdef FIFO_WR_ARB_BURST_EN
    seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
`else
    seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("pair%0d grant", k), 32'(grant), 32'(seq[k]));
      tick();
    end
    chk("pair full", 32'(full), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
